mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter XLEN, default 64: address and data width.
REQ-002 The block SHALL have parameter STARVE_MAX, default 4: max consecutive LSU grants while IFU waits.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 ifu_req_valid / ifu_req_ready  in / out  1  instruction-fetch read request handshake.
REQ-006 ifu_addr  in  XLEN  fetch address.
REQ-007 ifu_rsp_valid / ifu_rdata  out  1 / XLEN  fetch response pulse and data.
REQ-008 lsu_req_valid / lsu_req_ready  in / out  1  load/store request handshake.
REQ-009 lsu_addr, lsu_wdata  in  XLEN  access address, store data.
REQ-010 lsu_wen / lsu_wmask  in  1 / 8  store enable, byte-lane mask.
REQ-011 lsu_rsp_valid / lsu_rdata  out  1 / XLEN  load/store response pulse and data.
REQ-012 mem_req_valid / mem_req_ready  out / in  1  shared memory port request handshake.
REQ-013 mem_addr, mem_wdata  out  XLEN; mem_wen / mem_wmask  out  1 / 8  forwarded request fields.
REQ-014 mem_rsp_valid / mem_rdata  in  1 / XLEN  memory response, one per accepted request (writes included).
REQ-015 busy  out  1  high whenever state is not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, REQ, RESP; exactly one transaction outstanding at any time.
REQ-017 In IDLE, grant SHALL be combinational: LSU wins when both valid, except IFU wins when lsu_streak == STARVE_MAX.
REQ-018 Granted requester's req_ready SHALL be 1 in that IDLE cycle; all req_ready SHALL be 0 in REQ and RESP.
REQ-019 On grant, address, wen, wdata, wmask and owner SHALL be registered; IFU grant registers wen=0, wmask=0, wdata=0; state -> REQ.
REQ-020 In REQ, mem_req_valid SHALL be 1 with registered fields held stable; on mem_req_ready=1 state -> RESP next cycle.
REQ-021 In RESP, on mem_rsp_valid=1 the owner's rsp_valid SHALL be 1 in the same cycle with rdata = mem_rdata; state -> IDLE.
REQ-022 Non-owner rsp_valid SHALL stay 0; rdata outputs SHALL be 0 when their rsp_valid is 0.
REQ-023 mem_rsp_valid in IDLE or REQ SHALL be ignored (no response pulse, no state change).
REQ-024 Minimum latency: grant cycle N, mem_req_valid cycle N+1, earliest response cycle N+2; next grant earliest N+3.
REQ-025 lsu_streak (width clog2(STARVE_MAX)+1) SHALL increment on LSU grant with ifu_req_valid=1, clear on IFU grant, clear on LSU grant with ifu_req_valid=0; saturates at STARVE_MAX.
REQ-026 mem_req_valid, mem_wen, mem_wmask SHALL be 0 outside REQ; mem_addr/mem_wdata hold last registered values.
REQ-027 A requester deasserting valid before grant SHALL lose nothing; request fields after grant are not sampled.

Reset
REQ-028 With rst_n=0 at a rising edge: state=IDLE, lsu_streak=0, registered fields=0; all outputs 0 while rst_n=0.
REQ-029 Reset in REQ or RESP SHALL abandon the transaction; a later mem_rsp_valid SHALL produce no response.

Verification
REQ-030 IFU only, ifu_addr=0x80000000, mem_req_ready=1, mem_rsp_valid 1 cycle after -> mem_addr=0x80000000, mem_wen=0, ifu_rsp_valid one cycle with ifu_rdata=mem_rdata.
REQ-031 Both valid in IDLE, lsu_wen=1, lsu_wmask=0x0F, lsu_wdata=0x1122334455667788 -> LSU granted, mem fields match, lsu_rsp_valid pulse, IFU still pending.
REQ-032 Both held valid continuously, STARVE_MAX=4 -> grant order LSU x4, IFU, LSU x4, IFU; lsu_streak never exceeds 4.
REQ-033 mem_req_ready low 5 cycles in REQ -> mem_req_valid and fields stable 5 cycles, no req_ready asserted, busy=1.
REQ-034 rst_n=0 for one cycle during RESP, then mem_rsp_valid=1 -> no rsp_valid pulse, state IDLE, busy=0.
REQ-035 Spurious mem_rsp_valid=1 in IDLE -> no rsp_valid on either side, no state change.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / load-store) arbiter onto one shared memory port.
// One transaction is outstanding at a time; LSU has priority with bounded IFU starvation.
module mem_arbiter #(
    parameter int XLEN       = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            ifu_req_valid,
    output logic            ifu_req_ready,
    input  logic [XLEN-1:0] ifu_addr,
    output logic            ifu_rsp_valid,
    output logic [XLEN-1:0] ifu_rdata,

    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic [XLEN-1:0] lsu_addr,
    input  logic [XLEN-1:0] lsu_wdata,
    input  logic            lsu_wen,
    input  logic [7:0]      lsu_wmask,
    output logic            lsu_rsp_valid,
    output logic [XLEN-1:0] lsu_rdata,

    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_wen,
    output logic [7:0]      mem_wmask,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rdata,

    output logic            busy
);

    localparam int SW = $clog2(STARVE_MAX) + 1;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   lsu_streak;
    logic [XLEN-1:0] addr_q, wdata_q;
    logic            wen_q;
    logic [7:0]      wmask_q;
    logic            owner_lsu_q;
    logic            grant_ifu, grant_lsu;
    logic            rsp_fire;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (lsu_req_valid && ifu_req_valid) begin
                    if (lsu_streak == SW'(STARVE_MAX)) grant_ifu = 1'b1;
                    else                               grant_lsu = 1'b1;
                end else if (lsu_req_valid) begin
                    grant_lsu = 1'b1;
                end else if (ifu_req_valid) begin
                    grant_ifu = 1'b1;
                end
                if (grant_ifu || grant_lsu) state_nxt = REQ;
            end
            REQ:     if (mem_req_ready) state_nxt = RESP;
            RESP:    if (mem_rsp_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            lsu_streak  <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wen_q       <= 1'b0;
            wmask_q     <= '0;
            owner_lsu_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_lsu) begin
                addr_q      <= lsu_addr;
                wdata_q     <= lsu_wdata;
                wen_q       <= lsu_wen;
                wmask_q     <= lsu_wmask;
                owner_lsu_q <= 1'b1;
                // Streak only counts LSU wins that actually made the IFU wait.
                if (!ifu_req_valid)                      lsu_streak <= '0;
                else if (lsu_streak != SW'(STARVE_MAX))  lsu_streak <= lsu_streak + SW'(1);
            end else if (grant_ifu) begin
                addr_q      <= ifu_addr;
                wdata_q     <= '0;
                wen_q       <= 1'b0;
                wmask_q     <= '0;
                owner_lsu_q <= 1'b0;
                lsu_streak  <= '0;
            end
        end
    end

    // All outputs are gated by rst_n so they read 0 throughout reset.
    assign rsp_fire      = rst_n & (state == RESP) & mem_rsp_valid;
    assign ifu_req_ready = rst_n & grant_ifu;
    assign lsu_req_ready = rst_n & grant_lsu;
    assign ifu_rsp_valid = rsp_fire & ~owner_lsu_q;
    assign lsu_rsp_valid = rsp_fire &  owner_lsu_q;
    assign ifu_rdata     = ifu_rsp_valid ? mem_rdata : '0;
    assign lsu_rdata     = lsu_rsp_valid ? mem_rdata : '0;
    assign mem_req_valid = rst_n & (state == REQ);
    assign mem_wen       = mem_req_valid & wen_q;
    assign mem_wmask     = mem_req_valid ? wmask_q : '0;
    assign mem_addr      = rst_n ? addr_q  : '0;
    assign mem_wdata     = rst_n ? wdata_q : '0;
    assign busy          = rst_n & (state != IDLE);

endmodule
